// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception sequencer.
package exc_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HANDLER = 2'd1,
      FAULT   = 2'd2
   } exc_state_t;

   localparam logic [3:0] ESR_IRQ     = 4'b0001;
   localparam logic [3:0] ESR_INVALID = 4'b0010;

endpackage

// File: rtl/irq_sync.sv
// Multi-stage synchroniser for the asynchronous device IRQ level.
module irq_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates IRQ vs decoder faults, owns ELR/ESR.
// Optional event counters are enabled with the EXC_CTRL_STATS_EN macro.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter int unsigned  N           = 64,
   parameter int unsigned  SYNC_STAGES = 2,
   parameter logic [N-1:0] EXC_VECTOR  = N'(64'hD8)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ExtIRQ,
   input  logic         NotAnInstr,
   input  logic         ERet,
   input  logic [N-1:0] PC,
   output logic         Exc,
   output logic         ERetTaken,
   output logic [N-1:0] ExcPC,
   output logic [N-1:0] ELR,
   output logic [3:0]   ESR,
   output logic         irq_ack,
   output logic         in_handler,
   output logic         fault
`ifdef EXC_CTRL_STATS_EN
   ,
   output logic [31:0]  irq_count,
   output logic [31:0]  fault_count
`endif
);

   exc_state_t   state_q, state_d;
   logic [N-1:0] elr_q, elr_d;
   logic [3:0]   esr_q, esr_d;
   logic         ack_wait_q, ack_wait_d;
   logic         irq_s, irq_pend;

   irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (ExtIRQ),
      .q_o    (irq_s)
   );

   // ack_wait blocks re-entry on the same held IRQ level until it drops.
   assign irq_pend = irq_s & ~ack_wait_q;

   always_comb begin
      state_d    = state_q;
      elr_d      = elr_q;
      esr_d      = esr_q;
      ack_wait_d = ack_wait_q & irq_s;
      Exc        = 1'b0;
      ERetTaken  = 1'b0;
      irq_ack    = 1'b0;
      case (state_q)
         RUN: begin
            if (NotAnInstr || ERet) begin
               Exc     = 1'b1;
               elr_d   = PC;
               esr_d   = ESR_INVALID;
               state_d = HANDLER;
            end else if (irq_pend) begin
               Exc        = 1'b1;
               irq_ack    = 1'b1;
               elr_d      = PC;
               esr_d      = ESR_IRQ;
               ack_wait_d = 1'b1;
               state_d    = HANDLER;
            end
         end
         HANDLER: begin
            if (ERet)            begin ERetTaken = 1'b1; state_d = RUN; end
            else if (NotAnInstr) state_d = FAULT;
         end
         FAULT:   state_d = FAULT;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         elr_q      <= '0;
         esr_q      <= '0;
         ack_wait_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         elr_q      <= elr_d;
         esr_q      <= esr_d;
         ack_wait_q <= ack_wait_d;
      end
   end

   assign ExcPC      = Exc ? EXC_VECTOR : (ERetTaken ? elr_q : '0);
   assign ELR        = elr_q;
   assign ESR        = esr_q;
   assign in_handler = (state_q == HANDLER);
   assign fault      = (state_q == FAULT);

`ifdef EXC_CTRL_STATS_EN
   logic [31:0] irq_cnt_q, flt_cnt_q;
   logic        invalid_entry, fault_entry;

   assign invalid_entry = (state_q == RUN) && (NotAnInstr || ERet);
   assign fault_entry   = (state_q == HANDLER) && (state_d == FAULT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_cnt_q <= '0;
         flt_cnt_q <= '0;
      end else begin
         if (irq_ack && (irq_cnt_q != '1))
            irq_cnt_q <= irq_cnt_q + 32'd1;
         if ((invalid_entry || fault_entry) && (flt_cnt_q != '1))
            flt_cnt_q <= flt_cnt_q + 32'd1;
      end
   end

   assign irq_count   = irq_cnt_q;
   assign fault_count = flt_cnt_q;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: per-cycle vector table plus reset/latency sequences.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ExtIRQ = 1'b0, NotAnInstr = 1'b0, ERet = 1'b0;
   logic [63:0] PC = '0;
   logic        Exc, ERetTaken, irq_ack, in_handler, fault;
   logic [63:0] ExcPC, ELR;
   logic [3:0]  ESR;
`ifdef EXC_CTRL_STATS_EN
   logic [31:0] irq_count, fault_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   exc_ctrl #(.N(64), .SYNC_STAGES(2), .EXC_VECTOR(64'hD8)) dut (
      .clk        (clk),
      .reset      (reset),
      .ExtIRQ     (ExtIRQ),
      .NotAnInstr (NotAnInstr),
      .ERet       (ERet),
      .PC         (PC),
      .Exc        (Exc),
      .ERetTaken  (ERetTaken),
      .ExcPC      (ExcPC),
      .ELR        (ELR),
      .ESR        (ESR),
      .irq_ack    (irq_ack),
      .in_handler (in_handler),
      .fault      (fault)
`ifdef EXC_CTRL_STATS_EN
      ,
      .irq_count  (irq_count),
      .fault_count(fault_count)
`endif
   );

   typedef struct {
      logic        ext, nai, eret;
      logic [63:0] pc;
      logic        exc, ert;
      logic [63:0] excpc, elr;
      logic [3:0]  esr;
      logic        ack, inh, flt;
   } vec_t;

   function automatic vec_t v(input logic ext, nai, eret, input logic [63:0] pc,
                              input logic exc, ert, input logic [63:0] excpc, elr,
                              input logic [3:0] esr, input logic ack, inh, flt);
      vec_t r;
      r.ext = ext; r.nai = nai; r.eret = eret; r.pc = pc;
      r.exc = exc; r.ert = ert; r.excpc = excpc; r.elr = elr;
      r.esr = esr; r.ack = ack; r.inh = inh; r.flt = flt;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, got, exp);
      end
   endtask

   vec_t tbl[23];

   initial begin
      //          ext nai ert pc      | exc ert excpc  elr     esr ack inh flt
      tbl[0]  = v(0, 1, 0, 64'h40,  1, 0, 64'hD8,  64'h0,   4'h0, 0, 0, 0);
      tbl[1]  = v(0, 0, 0, 64'hD8,  0, 0, 64'h0,   64'h40,  4'h2, 0, 1, 0);
      tbl[2]  = v(0, 0, 1, 64'hDC,  0, 1, 64'h40,  64'h40,  4'h2, 0, 1, 0);
      tbl[3]  = v(0, 0, 0, 64'h40,  0, 0, 64'h0,   64'h40,  4'h2, 0, 0, 0);
      tbl[4]  = v(1, 0, 0, 64'hF8,  0, 0, 64'h0,   64'h40,  4'h2, 0, 0, 0);
      tbl[5]  = v(1, 0, 0, 64'hFC,  0, 0, 64'h0,   64'h40,  4'h2, 0, 0, 0);
      tbl[6]  = v(1, 0, 0, 64'h100, 1, 0, 64'hD8,  64'h40,  4'h2, 1, 0, 0);
      tbl[7]  = v(1, 0, 0, 64'hD8,  0, 0, 64'h0,   64'h100, 4'h1, 0, 1, 0);
      tbl[8]  = v(1, 0, 1, 64'hDC,  0, 1, 64'h100, 64'h100, 4'h1, 0, 1, 0);
      tbl[9]  = v(1, 0, 0, 64'h100, 0, 0, 64'h0,   64'h100, 4'h1, 0, 0, 0);
      tbl[10] = v(0, 0, 0, 64'h104, 0, 0, 64'h0,   64'h100, 4'h1, 0, 0, 0);
      tbl[11] = v(0, 0, 0, 64'h108, 0, 0, 64'h0,   64'h100, 4'h1, 0, 0, 0);
      tbl[12] = v(0, 0, 0, 64'h10C, 0, 0, 64'h0,   64'h100, 4'h1, 0, 0, 0);
      tbl[13] = v(1, 0, 0, 64'h200, 0, 0, 64'h0,   64'h100, 4'h1, 0, 0, 0);
      tbl[14] = v(1, 0, 0, 64'h204, 0, 0, 64'h0,   64'h100, 4'h1, 0, 0, 0);
      tbl[15] = v(1, 1, 0, 64'h208, 1, 0, 64'hD8,  64'h100, 4'h1, 0, 0, 0);
      tbl[16] = v(1, 0, 0, 64'hD8,  0, 0, 64'h0,   64'h208, 4'h2, 0, 1, 0);
      tbl[17] = v(1, 0, 1, 64'hDC,  0, 1, 64'h208, 64'h208, 4'h2, 0, 1, 0);
      tbl[18] = v(1, 0, 0, 64'h208, 1, 0, 64'hD8,  64'h208, 4'h2, 1, 0, 0);
      tbl[19] = v(0, 0, 0, 64'hD8,  0, 0, 64'h0,   64'h208, 4'h1, 0, 1, 0);
      tbl[20] = v(0, 1, 0, 64'hDC,  0, 0, 64'h0,   64'h208, 4'h1, 0, 1, 0);
      tbl[21] = v(0, 0, 1, 64'hE0,  0, 0, 64'h0,   64'h208, 4'h1, 0, 0, 1);
      tbl[22] = v(1, 1, 0, 64'hE4,  0, 0, 64'h0,   64'h208, 4'h1, 0, 0, 1);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_exc", 0, Exc, 1'b0);
      chk("rst_ert", 0, ERetTaken, 1'b0);
      chk("rst_excpc", 0, ExcPC, 64'h0);
      chk("rst_elr", 0, ELR, 64'h0);
      chk("rst_esr", 0, ESR, 4'h0);
      chk("rst_ack", 0, irq_ack, 1'b0);
      chk("rst_inh", 0, in_handler, 1'b0);
      chk("rst_flt", 0, fault, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 23; i++) begin
         ExtIRQ = tbl[i].ext; NotAnInstr = tbl[i].nai; ERet = tbl[i].eret; PC = tbl[i].pc;
         @(negedge clk);
         chk("Exc", i, Exc, tbl[i].exc);
         chk("ERetTaken", i, ERetTaken, tbl[i].ert);
         chk("ExcPC", i, ExcPC, tbl[i].excpc);
         chk("ELR", i, ELR, tbl[i].elr);
         chk("ESR", i, ESR, tbl[i].esr);
         chk("irq_ack", i, irq_ack, tbl[i].ack);
         chk("in_handler", i, in_handler, tbl[i].inh);
         chk("fault", i, fault, tbl[i].flt);
         @(posedge clk); #1;
      end

`ifdef EXC_CTRL_STATS_EN
      chk("irq_count", 0, irq_count, 32'd2);
      chk("fault_count", 0, fault_count, 32'd3);
`endif

      // Asynchronous reset out of FAULT
      ExtIRQ = 0; NotAnInstr = 0; ERet = 0; PC = 64'h0;
      reset = 1'b0;
      #2;
      chk("arst_flt", 1, fault, 1'b0);
      chk("arst_inh", 1, in_handler, 1'b0);
      chk("arst_elr", 1, ELR, 64'h0);
      chk("arst_esr", 1, ESR, 4'h0);
      chk("arst_exc", 1, Exc, 1'b0);
`ifdef EXC_CTRL_STATS_EN
      chk("arst_irqcnt", 1, irq_count, 32'd0);
      chk("arst_fltcnt", 1, fault_count, 32'd0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // IRQ latency through a freshly reset synchroniser
      @(posedge clk); #1;
      ExtIRQ = 1'b1; PC = 64'h300;
      @(negedge clk); chk("lat_exc", 0, Exc, 1'b0);
      @(posedge clk); #1;
      @(negedge clk); chk("lat_exc", 1, Exc, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("lat_exc", 2, Exc, 1'b1);
      chk("lat_ack", 2, irq_ack, 1'b1);
      chk("lat_excpc", 2, ExcPC, 64'hD8);
      @(posedge clk); #1;
      ExtIRQ = 1'b0; PC = 64'hD8;
      @(negedge clk);
      chk("lat_inh", 3, in_handler, 1'b1);
      chk("lat_elr", 3, ELR, 64'h300);
      chk("lat_esr", 3, ESR, 4'h1);
      chk("lat_ack", 3, irq_ack, 1'b0);

      // Reset mid-handler returns to RUN
      reset = 1'b0;
      #1;
      chk("hrst_inh", 0, in_handler, 1'b0);
      chk("hrst_elr", 0, ELR, 64'h0);
      chk("hrst_esr", 0, ESR, 4'h0);
      chk("hrst_flt", 0, fault, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_exc", 0, Exc, 1'b0);
      chk("post_inh", 0, in_handler, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
